val2_seq_shifter: RTL and testbench
===================================

VAL2_SEQ_SHIFTER -- requirements
Module: val2_seq_shifter

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  operand bundle valid.
REQ-005 in_ready  output  1  block can accept a bundle this cycle.
REQ-006 shift_operand  input  12  instruction shifter-operand / offset_12 field.
REQ-007 val_rm  input  32  Rm register value.
REQ-008 imm  input  1  immediate-operand instruction (I bit).
REQ-009 mem_command  input  1  LDR/STR instruction.
REQ-010 flush  input  1  synchronous abort of any in-flight operation.
REQ-011 out_valid  output  1  val2 result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 val2  output  32  computed second operand.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, SHIFT, DONE. Registers: acc[31:0], cnt[4:0], op[1:0].
REQ-016 in_ready SHALL equal (state==IDLE) && !flush; accept = in_valid && in_ready.
REQ-017 On accept with mem_command=1, acc SHALL load {20'b0, shift_operand} and cnt SHALL load 0; mem_command takes priority over imm.
REQ-018 On accept with imm=1 and mem_command=0: acc SHALL load {24'b0, shift_operand[7:0]}, op=ROR, cnt=2*shift_operand[11:8] (range 0..30).
REQ-019 On accept otherwise: acc SHALL load val_rm, op=shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR), cnt=shift_operand[11:7] (range 0..31).
REQ-020 On accept, next state SHALL be DONE if loaded cnt==0, else SHIFT; cnt==0 leaves acc unchanged for every op (no RRX, no shift-by-32 interpretation).
REQ-021 In SHIFT, each clock SHALL apply one 1-bit step to acc and decrement cnt: LSL zero-fill left; LSR zero-fill right; ASR replicate acc[31]; ROR acc[0] into bit 31.
REQ-022 SHIFT SHALL transition to DONE on the edge that performs the step taking cnt from 1 to 0.
REQ-023 Latency: with accept in cycle 0 and N = loaded cnt, out_valid SHALL first be high in cycle N+1.
REQ-024 In DONE, out_valid SHALL be 1 and val2 SHALL equal acc; both SHALL stay stable until out_valid && out_ready.
REQ-025 On out_valid && out_ready, next state SHALL be IDLE; no new bundle is accepted in the same cycle.
REQ-026 In IDLE and SHIFT, out_valid SHALL be 0; val2 SHALL hold its last registered value and is don't-care for consumers.
REQ-027 flush=1 SHALL, at the next edge, force state to IDLE and out_valid to 0 from any state; it overrides accept, stepping and out_ready completion, and acc is not updated on that edge.
REQ-028 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-029 Operand inputs SHALL be sampled only on accept; input changes during SHIFT/DONE SHALL not affect the result.

Reset
REQ-030 While rst=1, without waiting for a clock edge: state=IDLE, acc=0, cnt=0, op=0, val2=0, out_valid=0, busy=0, in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight operation; after release the first accept SHALL behave as from power-up.

Verification
REQ-032 mem_command=1, imm=1, shift_operand=12'hABC -> val2=32'h00000ABC, out_valid in cycle 1, no SHIFT state visited.
REQ-033 imm=1, shift_operand=12'h4FF -> 8 SHIFT cycles, val2=32'hFF000000, out_valid in cycle 9.
REQ-034 imm=0, shift_operand=12'h240 (ASR #4), val_rm=32'h80000010 -> val2=32'hF8000001, out_valid in cycle 5.
REQ-035 imm=0, shift_operand=12'hFE0 (ROR #31), val_rm=32'h00000001, out_ready low 3 cycles after out_valid -> val2=32'h00000002 held stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-036 LSL #10 in progress, flush pulsed at 3rd SHIFT cycle with in_valid=1 -> out_valid never asserts, bundle not accepted that cycle, in_ready=1 next cycle; following LSL #1 of 32'h1 -> val2=32'h00000002.
REQ-037 rst asserted between clock edges during SHIFT -> val2=0, out_valid=0, busy=0 immediately; next op after release correct.

Source files
------------

// File: rtl/val2_seq_shifter.sv
// val2_seq_shifter: multi-cycle barrel-shift replacement that builds the
// second ALU operand (val2) one bit per clock. Operands are captured on
// accept, shifted in SHIFT, and presented with a valid/ready handshake in DONE.
module val2_seq_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] shift_operand,
  input  logic [31:0] val_rm,
  input  logic        imm,
  input  logic        mem_command,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] val2,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic [1:0]  op;

  logic        accept;
  logic [31:0] load_acc;
  logic [4:0]  load_cnt;
  logic [1:0]  load_op;
  logic [31:0] step_acc;

  // Flush blocks acceptance in the same cycle so an aborted pipeline never
  // hands us a bundle that is about to be discarded.
  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // acc is untouched in DONE, so val2 is stable for the whole handshake.
  assign val2      = acc;

  // Decode the operand bundle into initial accumulator, count and shift type.
  // Load/store offsets win over the immediate form and are never shifted.
  always_comb begin
    load_acc = val_rm;
    load_cnt = shift_operand[11:7];
    load_op  = shift_operand[6:5];
    if (mem_command) begin
      load_acc = {20'b0, shift_operand};
      load_cnt = 5'd0;
      load_op  = OP_LSL;
    end else if (imm) begin
      load_acc = {24'b0, shift_operand[7:0]};
      load_cnt = {shift_operand[11:8], 1'b0};
      load_op  = OP_ROR;
    end
  end

  // One-bit step of the selected shift applied to the accumulator.
  always_comb begin
    step_acc = acc;
    case (op)
      OP_LSL:  step_acc = {acc[30:0], 1'b0};
      OP_LSR:  step_acc = {1'b0, acc[31:1]};
      OP_ASR:  step_acc = {acc[31], acc[31:1]};
      OP_ROR:  step_acc = {acc[0], acc[31:1]};
      default: step_acc = acc;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (load_cnt == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // cnt is never zero here; <= 1 keeps a corrupted count from hanging.
        if (cnt <= 5'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Datapath: capture operands on accept, step while shifting, freeze on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 32'd0;
      cnt <= 5'd0;
      op  <= 2'd0;
    end else if (!flush) begin
      if (accept) begin
        acc <= load_acc;
        cnt <= load_cnt;
        op  <= load_op;
      end else if (state == SHIFT) begin
        acc <= step_acc;
        cnt <= cnt - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_val2_seq_shifter.sv
// Directed testbench for val2_seq_shifter: hand-computed vectors covering the
// memory, immediate and register-shift forms, back-pressure, flush and reset.
module tb_val2_seq_shifter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] shift_operand;
  logic [31:0] val_rm;
  logic        imm;
  logic        mem_command;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  val2_seq_shifter dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .shift_operand (shift_operand),
    .val_rm        (val_rm),
    .imm           (imm),
    .mem_command   (mem_command),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .val2          (val2),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one bundle, measure latency to out_valid, optionally stall the
  // consumer for 'hold' cycles, then complete the handshake.
  task automatic do_op(input string tag, input logic [11:0] so, input logic [31:0] rm,
                       input logic i_imm, input logic i_mem,
                       input logic [31:0] exp_val, input int exp_lat, input int hold);
    int k;
    @(negedge clk);
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    shift_operand = so;
    val_rm        = rm;
    imm           = i_imm;
    mem_command   = i_mem;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    // Scramble operands: result must depend only on the accepted bundle.
    shift_operand = 12'hFFF;
    val_rm        = 32'hDEADBEEF;
    imm           = ~i_imm;
    mem_command   = ~i_mem;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_val"}, val2, exp_val);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_nrdy"}, {31'b0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_hold_d"}, val2, exp_val);
      check({tag, "_hold_r"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {30'b0, busy, out_valid}, 32'd0);
    $display("op %s: val2=%08h latency=%0d", tag, exp_val, k);
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    shift_operand = 12'h0;
    val_rm        = 32'h0;
    imm           = 1'b0;
    mem_command   = 1'b0;
    flush         = 1'b0;
    out_ready     = 1'b0;
    #2;
    check("rst_val2", val2, 32'd0);
    check("rst_flags", {29'b0, in_ready, busy, out_valid}, 32'b100);
    #10;
    rst = 1'b0;

    // Memory offset wins over imm, no shift.
    do_op("mem",     12'hABC, 32'h11111111, 1'b1, 1'b1, 32'h00000ABC, 1, 0);
    // Immediate 0xFF rotated right by 8.
    do_op("imm_ror8", 12'h4FF, 32'h0,       1'b1, 1'b0, 32'hFF000000, 9, 0);
    // Immediate with zero rotation.
    do_op("imm_rot0", 12'h0AB, 32'h0,       1'b1, 1'b0, 32'h000000AB, 1, 0);
    // ASR #4 sign-extends.
    do_op("asr4",    12'h240, 32'h80000010, 1'b0, 1'b0, 32'hF8000001, 5, 0);
    // LSR #3 zero-fills.
    do_op("lsr3",    12'h1A0, 32'hF0000000, 1'b0, 1'b0, 32'h1E000000, 4, 0);
    // LSL #0 and ROR #0 leave the value untouched (no RRX).
    do_op("lsl0",    12'h000, 32'h12345678, 1'b0, 1'b0, 32'h12345678, 1, 0);
    do_op("ror0",    12'h060, 32'h80000001, 1'b0, 1'b0, 32'h80000001, 1, 0);
    // ROR #31 with 3 stall cycles from the consumer.
    do_op("ror31",   12'hFE0, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 32, 3);

    // Flush during the 3rd SHIFT cycle of LSL #10 with a new bundle offered.
    @(negedge clk);
    shift_operand = 12'h500;
    val_rm        = 32'h00000001;
    imm           = 1'b0;
    mem_command   = 1'b0;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("flush_nrdy", {30'b0, in_ready, busy}, 32'b01);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", {29'b0, in_ready, busy, out_valid}, 32'b100);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (out_valid || busy) seen++;
      end
      check("flush_quiet", seen, 0);
    end
    $display("op flush: aborted LSL #10");
    do_op("lsl1",    12'h080, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 2, 0);

    // Asynchronous reset between edges during SHIFT.
    @(negedge clk);
    shift_operand = 12'h500;
    val_rm        = 32'h0000F00F;
    imm           = 1'b0;
    mem_command   = 1'b0;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_val2", val2, 32'd0);
    check("arst_flags", {29'b0, in_ready, busy, out_valid}, 32'b100);
    @(negedge clk);
    rst = 1'b0;
    $display("op reset: aborted LSL #10");
    do_op("asr4_b",  12'h240, 32'h80000010, 1'b0, 1'b0, 32'hF8000001, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
